uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter; legal range 2..16.
REQ-002 Parameter INPUT_DATA_WIDTH, default 8: byte width, equal to the transmitter data width.
REQ-003 Parameter BUSY_TIMEOUT, default 16: maximum number of cycles to wait for tx_busy to rise after launch.
REQ-004 Port list, one per line:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  level request per requester; bit i is held high until grant[i] pulses.
- req_data  input  NUM_REQ*INPUT_DATA_WIDTH  byte of requester i in slice [i*W +: W]; stable while req[i] is high.
- grant  output  NUM_REQ  one-hot, one-cycle pulse; byte of requester i accepted.
- tx_enable  output  1  one-cycle launch strobe to the transmitter enable input.
- tx_data  output  INPUT_DATA_WIDTH  registered byte to the transmitter i_data input.
- tx_busy  input  1  transmitter o_busy.
- active_id  output  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
- idle  output  1  high when the FSM is in IDLE.
- timeout_err  output  1  sticky flag; tx_busy failed to rise within BUSY_TIMEOUT cycles.

Function
REQ-005 The FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE, encoded in 2 bits.
REQ-006 In IDLE with req != 0 and tx_busy low, the block SHALL select a winner and move to LAUNCH on the next edge; in IDLE with tx_busy high, it SHALL stay in IDLE.
REQ-007 Winner selection SHALL be round-robin: search from (last_id+1) mod NUM_REQ upward with wrap, and take the first set req bit.
REQ-008 In the winner-select edge, the block SHALL load tx_data from the winner's slice, load active_id, and set last_id to the winner.
REQ-009 In LAUNCH, tx_enable SHALL be 1 and grant[active_id] SHALL be 1 for exactly that one cycle; next state is WAIT_BUSY.
REQ-010 In WAIT_BUSY, the block SHALL move to WAIT_DONE when tx_busy=1.
- If tx_busy=1 is already sampled in the LAUNCH cycle, it SHALL go LAUNCH -> WAIT_DONE directly.
REQ-011 In WAIT_BUSY, a counter SHALL increment each cycle; when the count reaches BUSY_TIMEOUT, the block SHALL set timeout_err and return to IDLE.
- The grant already given SHALL NOT be repeated.
REQ-012 In WAIT_DONE, the block SHALL return to IDLE on the first cycle with tx_busy=0.
- Minimum spacing between consecutive tx_enable pulses: 3 cycles plus the transmitter busy time.
REQ-013 tx_enable and grant SHALL be 0 in all states other than LAUNCH.
- grant SHALL never have more than one bit set.
REQ-014 A req bit that drops before selection SHALL NOT be granted.
- A req bit that changes after selection SHALL NOT affect tx_data or the current transaction.
REQ-015 A requester whose req stays high after its grant SHALL be re-eligible only in round-robin order; no requester is served twice while another has a pending request.
REQ-016 tx_data and active_id SHALL hold their values from selection until the next selection.
REQ-017 idle SHALL be a registered decode of state == IDLE.
REQ-018 timeout_err SHALL clear only on reset.

Reset
REQ-019 While reset is low, the block SHALL asynchronously force the following values:
- state = IDLE
- grant = 0, tx_enable = 0, tx_data = 0, active_id = 0
- idle = 1, timeout_err = 0
- timeout counter = 0
- last_id = NUM_REQ-1, so that requester 0 has first priority
REQ-020 Reset asserted mid-transaction SHALL abandon the transaction with no further grant or tx_enable; the requester keeps req high and is re-arbitrated after release.
REQ-021 The first selection SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single requester: req=0001, data0=0xA5 -> grant=0001 and tx_enable=1 in the same cycle, 2 cycles after req rises; tx_data=0xA5.
- All requesting: req=1111 held for 4 transactions -> grant order 0,1,2,3, then 0 again on the 5th.
- Mid-stream join: req=0101 with last_id=0 -> requester 2 served before requester 0.
- Timeout: tx_busy tied 0 with BUSY_TIMEOUT=16 -> timeout_err=1 exactly 16 cycles after the WAIT_BUSY entry; FSM back in IDLE; the next request is still served.
- Reset in WAIT_DONE: reset asserted -> all outputs at reset values immediately; after release, requester 0 is granted first.
- Pre-busy: tx_busy high when req arrives -> no grant until tx_busy falls; then normal launch.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmitter bundle for uart_tx_arbiter: per-requester level
// requests and bytes on one side, the shared UART transmitter on the other.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                  grant;
  logic                                tx_enable;
  logic [INPUT_DATA_WIDTH-1:0]         tx_data;
  logic                                tx_busy;
  logic [ID_W-1:0]                     active_id;
  logic                                idle;
  logic                                timeout_err;

  // Arbiter side
  modport master (
    input  req, req_data, tx_busy,
    output grant, tx_enable, tx_data, active_id, idle, timeout_err
  );

  // Requesters plus transmitter side
  modport slave (
    output req, req_data, tx_busy,
    input  grant, tx_enable, tx_data, active_id, idle, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters;
// launches one byte at a time and watches tx_busy for start and completion.
module uart_tx_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int BUSY_TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.master   bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                      state, next_state;
  logic [ID_W-1:0]             last_id, active_id, winner;
  logic                        found, select, cnt_expired;
  logic [INPUT_DATA_WIDTH-1:0] tx_data;
  logic [CNT_W-1:0]            busy_cnt;
  logic                        idle, timeout_err;
  logic                        tx_enable;
  logic [NUM_REQ-1:0]          grant;

  // Round-robin search: walk offsets from the highest down so the last hit,
  // which wins, is the closest requester after last_id.
  always_comb begin
    int idx;
    // NOTE: every comb output gets a default first so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[ID_W'(idx)]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign select      = (state == IDLE) && found && !bus.tx_busy;
  assign cnt_expired = (state == WAIT_BUSY) && !bus.tx_busy &&
                       (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (select) next_state = LAUNCH;
      LAUNCH:    next_state = bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)      next_state = WAIT_DONE;
        else if (cnt_expired) next_state = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode: launch strobe and grant exist only in LAUNCH
  always_comb begin
    tx_enable = 1'b0;
    grant     = '0;
    if (state == LAUNCH) begin
      tx_enable        = 1'b1;
      grant[active_id] = 1'b1;
    end
  end

  // Datapath, timeout counter and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data     <= '0;
      active_id   <= '0;
      last_id     <= ID_W'(NUM_REQ - 1);
      busy_cnt    <= '0;
      idle        <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      if (select) begin
        tx_data   <= bus.req_data[winner*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
        active_id <= winner;
        last_id   <= winner;
      end
      // Counts only consecutive non-busy cycles spent in WAIT_BUSY
      if (state == WAIT_BUSY && !bus.tx_busy && !cnt_expired)
        busy_cnt <= busy_cnt + 1'b1;
      else
        busy_cnt <= '0;
      if (cnt_expired) timeout_err <= 1'b1;
      idle <= (next_state == IDLE);
    end
  end

  assign bus.grant       = grant;
  assign bus.tx_enable   = tx_enable;
  assign bus.tx_data     = tx_data;
  assign bus.active_id   = active_id;
  assign bus.idle        = idle;
  assign bus.timeout_err = timeout_err;
endmodule
